// File: rtl/seq_checker.sv
// Receive-side checker for the 4-bit, 13-state sequence generator: hunts for lock,
// then flywheels a prediction, flagging and counting mismatches.
module seq_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             match,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       seq_idx,
    output logic             period_done
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    logic             have_prev_r;
    logic [3:0]       match_run_r;
    logic [3:0]       miss_run_r;
    logic [3:0]       prev_r;
    logic [3:0]       expected_r;

    logic [3:0]       din_idx_s;
    logic [3:0]       din_succ_s;
    logic [3:0]       hunt_run_s;
    logic [3:0]       miss_run_s;
    logic             cnt_inc_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Successor in the generator cycle; illegal codes map to 0000, which never
    // counts as a correct successor because 0000 is itself illegal.
    function automatic logic [3:0] seq_succ(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'b1000: r = 4'b0111;
            4'b0111: r = 4'b1011;
            4'b1011: r = 4'b0100;
            4'b0100: r = 4'b0010;
            4'b0010: r = 4'b0101;
            4'b0101: r = 4'b1100;
            4'b1100: r = 4'b0110;
            4'b0110: r = 4'b0011;
            4'b0011: r = 4'b1111;
            4'b1111: r = 4'b0001;
            4'b0001: r = 4'b1110;
            4'b1110: r = 4'b1101;
            4'b1101: r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Position of a code in the cycle; 4'hF marks an illegal code.
    function automatic logic [3:0] seq_index(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'b1000: r = 4'd0;
            4'b0111: r = 4'd1;
            4'b1011: r = 4'd2;
            4'b0100: r = 4'd3;
            4'b0010: r = 4'd4;
            4'b0101: r = 4'd5;
            4'b1100: r = 4'd6;
            4'b0110: r = 4'd7;
            4'b0011: r = 4'd8;
            4'b1111: r = 4'd9;
            4'b0001: r = 4'd10;
            4'b1110: r = 4'd11;
            4'b1101: r = 4'd12;
            default: r = 4'hF;
        endcase
        return r;
    endfunction

    // Next-state helpers: hunt run length, miss run length and error counter update.
    always_comb begin
        din_idx_s  = seq_index(din);
        din_succ_s = seq_succ(din);
        miss_run_s = miss_run_r + 4'd1;
        hunt_run_s = 4'd0;
        if ((din_idx_s != 4'hF) && have_prev_r && (din == seq_succ(prev_r))) begin
            hunt_run_s = match_run_r + 4'd1;
        end else begin
            hunt_run_s = 4'd0;
        end
        cnt_inc_s = din_valid && (state_r == LOCKED) && (din != expected_r);
        if (clr_cnt) begin
            cnt_next_s = cnt_inc_s ? CNT_ONE : {CNT_W{1'b0}};
        end else if (cnt_inc_s && (err_cnt != CNT_MAX)) begin
            cnt_next_s = err_cnt + CNT_ONE;
        end else begin
            cnt_next_s = err_cnt;
        end
    end

    // Lock FSM with registered status outputs; pulses clear whenever no word arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= HUNT;
            have_prev_r <= 1'b0;
            match_run_r <= 4'd0;
            miss_run_r  <= 4'd0;
            prev_r      <= 4'd0;
            expected_r  <= 4'd0;
            locked      <= 1'b0;
            match       <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= {CNT_W{1'b0}};
            seq_idx     <= 4'hF;
            period_done <= 1'b0;
        end else begin
            err_cnt     <= cnt_next_s;
            match       <= 1'b0;
            err         <= 1'b0;
            period_done <= 1'b0;
            if (din_valid) begin
                seq_idx     <= din_idx_s;
                prev_r      <= din;
                have_prev_r <= 1'b1;
                case (state_r)
                    HUNT: begin
                        if (hunt_run_s == LOCK_N) begin
                            state_r     <= LOCKED;
                            locked      <= 1'b1;
                            expected_r  <= din_succ_s;
                            miss_run_r  <= 4'd0;
                            match_run_r <= 4'd0;
                        end else begin
                            match_run_r <= hunt_run_s;
                        end
                    end
                    LOCKED: begin
                        if (din == expected_r) begin
                            match       <= 1'b1;
                            miss_run_r  <= 4'd0;
                            expected_r  <= din_succ_s;
                            period_done <= (din == 4'b1101);
                        end else begin
                            err <= 1'b1;
                            if (miss_run_s == UNLOCK_N) begin
                                state_r     <= HUNT;
                                locked      <= 1'b0;
                                match_run_r <= 4'd0;
                                miss_run_r  <= 4'd0;
                            end else begin
                                // Flywheel: keep predicting through the bad word.
                                miss_run_r <= miss_run_s;
                                expected_r <= seq_succ(expected_r);
                            end
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
Receive-side companion to the 4-bit 13-state sequence generator. Samples a 4-bit word stream qualified by din_valid and locks onto the generator's fixed cycle. Once locked, checks every word against a flywheel prediction, flags mismatches and counts them, and reports position in the cycle. Sits at the far end of the generator link as a built-in self-test / link monitor.

Parameters:
LOCK_CNT, 3, consecutive correct successor transitions needed to lock (1..15)
UNLOCK_CNT, 2, consecutive mismatches while locked that force loss of lock (1..15)
CNT_W, 16, width of the error counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
din  input  4  received sequence word
din_valid  input  1  din is sampled only on edges where this is 1
clr_cnt  input  1  synchronous clear of err_cnt
locked  output  1  checker is in LOCKED state
match  output  1  1-cycle pulse: last valid word equalled the prediction while LOCKED
err  output  1  1-cycle pulse: last valid word mismatched while LOCKED
err_cnt  output  CNT_W  saturating count of LOCKED mismatches
seq_idx  output  4  cycle index of last valid word; 4'hF if illegal code
period_done  output  1  1-cycle pulse: 4'b1101 received as a match while LOCKED

Behaviour:
- Cycle, index 0..12: 1000,0111,1011,0100,0010,0101,1100,0110,0011,1111,0001,1110,1101, then back to 1000. succ(x) is the next entry. Illegal codes: 0000, 1001, 1010.
- Reset: locked=0, match=0, err=0, err_cnt=0, seq_idx=4'hF, period_done=0. Internal state: state=HUNT, have_prev=0, match_run=0, miss_run=0, prev=0, expected=0.
- All outputs are registered and update on the edge that samples din_valid=1. Latency is one clock.
- din_valid=0: all state holds; match, err and period_done drop to 0.
- seq_idx is updated on every valid word in both states.
- FSM has two states, HUNT and LOCKED.
- HUNT, on each valid word:
  - Illegal code: match_run=0.
  - have_prev=1 and din==succ(prev): match_run+1.
  - Otherwise: match_run=0.
  - Always: prev<=din, have_prev<=1.
  - When match_run reaches LOCK_CNT: go to LOCKED on that same edge, expected<=succ(din), miss_run=0. This takes LOCK_CNT+1 consecutive correct words; with the default, lock asserts on the 4th word's edge.
  - HUNT never asserts err or match and never changes err_cnt.
- LOCKED, on each valid word:
  - din==expected: match=1, miss_run=0, expected<=succ(din). period_done=1 if din==1101.
  - Otherwise, including illegal codes: err=1, err_cnt+1 (saturates at all-ones), miss_run+1, and the flywheel advances expected<=succ(expected).
  - When miss_run reaches UNLOCK_CNT on a mismatch: go to HUNT on that edge, locked=0, match_run=0, have_prev=1, prev<=din. That final mismatch is still counted and still pulses err.
- clr_cnt=1 sets err_cnt to 0, independent of din_valid. If an increment occurs on the same edge, err_cnt becomes 1.
- Reset mid-stream returns to HUNT immediately. The next lock needs LOCK_CNT+1 fresh correct words.
- Wrap 1101→1000 is a normal correct transition in both states.

Test Plan:
- Reset, then feed 1000,0111,1011,0100 with valid=1 → locked=0 after words 1–3, locked=1 after the 4th edge; seq_idx=3; err_cnt=0.
- Locked, feed a full cycle ending with 1101 then 1000 → match pulses on every word; period_done=1 only for the 1101 edge; seq_idx 12 then 0.
- Locked after 0010 (expected 0101), feed 1111 then 1100 → err=1 for one cycle, err_cnt=1, stays locked; 1100 gives match=1 via flywheel.
- Locked, feed two wrong words 0000, 1010 → err pulses twice, err_cnt=2, locked=0 after the 2nd edge, seq_idx=4'hF; then feed 0111,1011,0100,0010 → locked=1 again.
- Locked with valid toggling 1,0,0,1 across correct words, and assert rst mid-stream → no false errors while valid=0; on rst, all outputs return to reset values within the cycle, without a clock.
- CNT_W=2: force 5 mismatches with UNLOCK_CNT=15 → err_cnt saturates at 3. Then clr_cnt on the same edge as a mismatch → err_cnt=1.
